lvds_capture_engine: RTL
========================

Name: lvds_capture_engine

Overview:
Parametrised successor of the single-shot LVDS capture controller, running entirely in the LVDS data clock domain. It captures NUM_LANES-wide samples into an external capture buffer through a simple write port. Three modes are supported: immediate, triggered, and continuous. Decimation, a pre/post-trigger ring buffer, trigger-address reporting and abort are included. The AXI-side register block supplies the START, ABORT and configuration signals, already synchronised into this domain.

Parameters:
NUM_LANES, 4, LVDS data lanes per sample (WR_DATA width)
DEPTH, 512, buffer entries; 2 <= DEPTH <= 2**ADDR_WIDTH (power of two not required)
ADDR_WIDTH, 9, buffer address width
DECIM_WIDTH, 8, width of decimation ratio input

Ports:
LVDS_CLK  in  1  sole clock
LVDS_RST  in  1  reset, synchronous, active-high
LVDS_IN  in  NUM_LANES  sampled lane data
START  in  1  single-cycle start pulse, already synchronised
ABORT  in  1  single-cycle abort pulse, already synchronised
MODE  in  2  0=immediate, 1=triggered, 2=continuous, 3=treated as 0
POST_COUNT  in  ADDR_WIDTH  samples written after the trigger sample (mode 1)
TRIG_MASK  in  NUM_LANES  lanes participating in the trigger
TRIG_VALUE  in  NUM_LANES  required lane values for the trigger
DECIM  in  DECIM_WIDTH  keep 1 of every DECIM+1 samples
WR_EN  out  1  buffer write enable
WR_ADDR  out  ADDR_WIDTH  buffer write address
WR_DATA  out  NUM_LANES  buffer write data
BUSY  out  1  capture in progress
DONE  out  1  one-cycle completion pulse
TRIGGERED  out  1  trigger seen in the current/last capture
TRIG_ADDR  out  ADDR_WIDTH  address of the trigger sample
WRAPPED  out  1  address wrapped at least once in the current/last capture

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0; takes effect on the next edge, aborting any capture mid-operation (no DONE).
- States:
  - IDLE.
  - ARMED: mode 1, pre-trigger ring writing.
  - POST: mode 1 post-trigger countdown.
  - FILL: mode 0 and mode 2.
- MODE, POST_COUNT, TRIG_MASK, TRIG_VALUE and DECIM are latched on the accepted START. Changes while BUSY are ignored.
- IDLE + START (ABORT low):
  - clear TRIGGERED, WRAPPED, TRIG_ADDR;
  - load address counter 0 and decimation counter 0;
  - go to FILL (modes 0/2/3) or ARMED (mode 1).
  - BUSY=1 from the next cycle.
- START while BUSY is ignored. START and ABORT in the same cycle in IDLE: ABORT wins, no start.
- Strobe:
  - The decimation counter counts 0..DECIM and wraps. Strobe = counter==0 while in a writing state.
  - The first strobe is on the first cycle after START acceptance.
- Write path, registered:
  - A strobe at cycle n gives WR_EN=1 at n+1, with WR_DATA=LVDS_IN(n) and WR_ADDR=address counter(n).
  - The address counter then advances; DEPTH-1 wraps to 0 and sets WRAPPED.
  - WR_EN=0 on all non-strobe cycles; WR_ADDR/WR_DATA hold their last values.
- Mode 0:
  - Write addresses 0..DEPTH-1 once.
  - The cycle after the last WR_EN: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Mode 1:
  - ARMED writes a ring. Each strobe sample is tested: (LVDS_IN & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK).
  - TRIG_MASK=0 triggers on the first strobe.
  - The trigger sample is written. TRIGGERED=1 and TRIG_ADDR=its address are set together with its WR_EN.
  - Then POST_COUNT further strobe samples are written in POST. POST_COUNT > DEPTH-1 is clamped to DEPTH-1.
  - POST_COUNT=0: the trigger sample is the last write.
  - Completion is as in mode 0.
  - Only the first match counts; in POST the trigger logic is inert.
- Mode 2: ring writing continues indefinitely until ABORT; no DONE.
- ABORT in any non-IDLE state:
  - IDLE and BUSY=0 next cycle.
  - No WR_EN from the next cycle; a write already registered this cycle completes.
  - No DONE; TRIGGERED, TRIG_ADDR and WRAPPED keep their values.
- Latency: START(t) -> BUSY(t+1), first WR_EN(t+2). With DECIM=0 in mode 0: DONE and BUSY fall at t+DEPTH+2.

Test Plan:
1. DEPTH=16, DECIM=0, MODE=0, LVDS_IN=counter, START at t -> WR_EN t+2..t+17 with addresses 0..15 and data = LVDS_IN one cycle earlier; DONE high only at t+18; BUSY t+1..t+17; WRAPPED=1.
2. MODE=0, DECIM=2 -> WR_EN every 3rd cycle, 16 writes; DONE at t+48.
3. MODE=1, TRIG_MASK=4'b1111, TRIG_VALUE=4'hA, POST_COUNT=5; 4'hA applied at the 20th strobe -> TRIG_ADDR=3 (19 mod 16), TRIGGERED=1, exactly 5 writes after it (addresses 4..8), DONE, WRAPPED=1.
4. MODE=1, TRIG_MASK=0, POST_COUNT=20 -> TRIG_ADDR=0; post count clamped to 15; 16 writes total; DONE.
5. MODE=2, ABORT after 40 writes -> WR_EN stops the next cycle, BUSY=0, no DONE, WRAPPED=1; a second START while busy is ignored.
6. LVDS_RST asserted mid-capture in mode 1 -> all outputs 0 the next cycle; START+ABORT together in IDLE -> BUSY stays 0.

Source files
------------

// File: rtl/lvds_capture_engine.sv
// LVDS capture engine: writes NUM_LANES-wide samples into an external buffer in
// immediate, triggered (pre/post-trigger ring) or continuous mode, with decimation and abort.
module lvds_capture_engine #(
  parameter int NUM_LANES   = 4,
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = 9,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   LVDS_CLK,
  input  logic                   LVDS_RST,
  input  logic [NUM_LANES-1:0]   LVDS_IN,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [1:0]             MODE,
  input  logic [ADDR_WIDTH-1:0]  POST_COUNT,
  input  logic [NUM_LANES-1:0]   TRIG_MASK,
  input  logic [NUM_LANES-1:0]   TRIG_VALUE,
  input  logic [DECIM_WIDTH-1:0] DECIM,
  output logic                   WR_EN,
  output logic [ADDR_WIDTH-1:0]  WR_ADDR,
  output logic [NUM_LANES-1:0]   WR_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   TRIGGERED,
  output logic [ADDR_WIDTH-1:0]  TRIG_ADDR,
  output logic                   WRAPPED
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, POST, FILL} state_t;

  state_t                 state;
  logic                   continuous;
  logic                   finish_pending;
  logic [ADDR_WIDTH-1:0]  addr_cnt;
  logic [ADDR_WIDTH-1:0]  post_lat;
  logic [ADDR_WIDTH-1:0]  post_left;
  logic [DECIM_WIDTH-1:0] decim_lat;
  logic [DECIM_WIDTH-1:0] decim_cnt;
  logic [NUM_LANES-1:0]   mask_lat;
  logic [NUM_LANES-1:0]   value_lat;

  logic                   strobe;
  logic                   trig_hit;
  logic                   at_last_addr;
  logic [ADDR_WIDTH-1:0]  next_addr;

  always_comb begin
    strobe       = (state != IDLE) && !finish_pending && (decim_cnt == '0);
    trig_hit     = ((LVDS_IN ^ value_lat) & mask_lat) == '0;
    at_last_addr = (addr_cnt == LAST_ADDR);
    next_addr    = at_last_addr ? '0 : addr_cnt + ADDR_WIDTH'(1);
  end

  // finish_pending holds BUSY for the cycle of the final write so DONE follows it.
  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RST) begin
      state          <= IDLE;
      continuous     <= 1'b0;
      finish_pending <= 1'b0;
      addr_cnt       <= '0;
      post_lat       <= '0;
      post_left      <= '0;
      decim_lat      <= '0;
      decim_cnt      <= '0;
      mask_lat       <= '0;
      value_lat      <= '0;
      WR_EN          <= 1'b0;
      WR_ADDR        <= '0;
      WR_DATA        <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      TRIGGERED      <= 1'b0;
      TRIG_ADDR      <= '0;
      WRAPPED        <= 1'b0;
    end else begin
      WR_EN <= 1'b0;
      DONE  <= 1'b0;
      if (state == IDLE) begin
        if (START && !ABORT) begin
          continuous     <= (MODE == 2'd2);
          post_lat       <= (POST_COUNT > LAST_ADDR) ? LAST_ADDR : POST_COUNT;
          decim_lat      <= DECIM;
          mask_lat       <= TRIG_MASK;
          value_lat      <= TRIG_VALUE;
          addr_cnt       <= '0;
          decim_cnt      <= '0;
          finish_pending <= 1'b0;
          TRIGGERED      <= 1'b0;
          TRIG_ADDR      <= '0;
          WRAPPED        <= 1'b0;
          BUSY           <= 1'b1;
          state          <= (MODE == 2'd1) ? ARMED : FILL;
        end
      end else if (ABORT) begin
        state          <= IDLE;
        BUSY           <= 1'b0;
        finish_pending <= 1'b0;
      end else if (finish_pending) begin
        state          <= IDLE;
        BUSY           <= 1'b0;
        DONE           <= 1'b1;
        finish_pending <= 1'b0;
      end else begin
        decim_cnt <= (decim_cnt == decim_lat) ? '0 : decim_cnt + DECIM_WIDTH'(1);
        if (strobe) begin
          WR_EN    <= 1'b1;
          WR_ADDR  <= addr_cnt;
          WR_DATA  <= LVDS_IN;
          addr_cnt <= next_addr;
          if (at_last_addr) WRAPPED <= 1'b1;
          case (state)
            FILL: begin
              if (!continuous && at_last_addr) finish_pending <= 1'b1;
            end
            ARMED: begin
              if (trig_hit) begin
                TRIGGERED <= 1'b1;
                TRIG_ADDR <= addr_cnt;
                if (post_lat == '0) begin
                  finish_pending <= 1'b1;
                end else begin
                  post_left <= post_lat;
                  state     <= POST;
                end
              end
            end
            POST: begin
              post_left <= post_left - ADDR_WIDTH'(1);
              if (post_left == ADDR_WIDTH'(1)) finish_pending <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
